// File: rtl/weight_ram_float16.sv
// Weight store for float16 convolution kernels: one full KxK slice written per cycle, one word read per cycle.
// Optional macro WEIGHT_RAM_WR_FWD_EN turns same-cycle read of a word being written into write-first.
module weight_ram_float16 #(
  parameter int DATA_WIDTH              = 16,
  parameter int KERNEL_SIZE_MAX         = 3,
  parameter int WEIGHT_WRITE_ADDR_WIDTH = 4,
  parameter int WEIGHT_READ_ADDR_WIDTH  = 8
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   ena_w,
  input  logic [WEIGHT_WRITE_ADDR_WIDTH-1:0]                     addr_write,
  input  logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*DATA_WIDTH-1:0]  din,
  input  logic                                                   ena_r,
  input  logic [WEIGHT_READ_ADDR_WIDTH-1:0]                      addr_read,
  output logic [DATA_WIDTH-1:0]                                  dout
);

  localparam int KS2    = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
  localparam int DEPTH  = 2 ** WEIGHT_WRITE_ADDR_WIDTH;
  localparam int WORDS  = DEPTH * KS2;
  localparam int MEM_AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;
  logic [MEM_AW-1:0]     wr_base_s;
  logic [MEM_AW-1:0]     rd_idx_s;
  logic                  rd_in_range_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
`ifdef WEIGHT_RAM_WR_FWD_EN
  logic [MEM_AW-1:0]     fwd_off_s;
`endif

  // Address decode and read-word selection.
  always_comb begin
    wr_base_s     = MEM_AW'(addr_write) * MEM_AW'(KS2);
    rd_in_range_s = (int'(addr_read) < WORDS);
    if (rd_in_range_s) begin
      rd_idx_s = addr_read[MEM_AW-1:0];
    end else begin
      rd_idx_s = {MEM_AW{1'b0}};
    end
`ifdef WEIGHT_RAM_WR_FWD_EN
    fwd_off_s = rd_idx_s - wr_base_s;
    // A read landing inside the slice being written sees the incoming element.
    if (ena_w && rd_in_range_s && (rd_idx_s >= wr_base_s) && (fwd_off_s < MEM_AW'(KS2))) begin
      rd_word_s = din[int'(fwd_off_s)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      rd_word_s = mem_q[rd_idx_s];
    end
`else
    rd_word_s = mem_q[rd_idx_s];
`endif
  end

  // Next read-data value: reset wins, out-of-range reads return zero, idle holds.
  always_comb begin
    if (!rst_n) begin
      dout_d = {DATA_WIDTH{1'b0}};
    end else if (ena_r) begin
      if (rd_in_range_s) begin
        dout_d = rd_word_s;
      end else begin
        dout_d = {DATA_WIDTH{1'b0}};
      end
    end else begin
      dout_d = dout_q;
    end
  end

  // Read-data register.
  always_ff @(posedge clk) begin
    dout_q <= dout_d;
  end

  // Slice write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && ena_w) begin
      for (int k = 0; k < KS2; k++) begin
        mem_q[wr_base_s + MEM_AW'(k)] <= din[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_weight_ram_float16.sv
// Self-checking bench for weight_ram_float16: reference memory model checked every cycle plus literal expectations.
module tb_weight_ram_float16;

  localparam int DW    = 16;
  localparam int KS2   = 9;
  localparam int WORDS = 144;

  logic           clk;
  logic           rst_n;
  logic           ena_w;
  logic [3:0]     addr_write;
  logic [KS2*DW-1:0] din;
  logic           ena_r;
  logic [7:0]     addr_read;
  logic [DW-1:0]  dout;

  int n_cmp;
  int n_fail;

  logic [DW-1:0] model_mem [WORDS];
  logic [DW-1:0] m_dout;
  logic          m_valid;

  weight_ram_float16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena_w      (ena_w),
    .addr_write (addr_write),
    .din        (din),
    .ena_r      (ena_r),
    .addr_read  (addr_read),
    .dout       (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: flat word array, read sampled before write is applied.
  always @(posedge clk) begin
    int base;
    int ar;
    base = int'(addr_write) * KS2;
    ar   = int'(addr_read);
    if (!rst_n) begin
      m_dout  = 16'h0000;
      m_valid = 1'b1;
    end else begin
      if (ena_r) begin
        if (ar >= WORDS) begin
          m_dout = 16'h0000;
        end else begin
          m_dout = model_mem[ar];
`ifdef WEIGHT_RAM_WR_FWD_EN
          if (ena_w && ar >= base && ar < base + KS2) m_dout = din[(ar-base)*DW +: DW];
`endif
        end
      end
      if (ena_w) begin
        for (int k = 0; k < KS2; k++) model_mem[base+k] = din[k*DW +: DW];
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      n_cmp++;
      if (dout !== m_dout) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: dout=%h expected=%h", $time, dout, m_dout);
      end
    end
  end

  task automatic step(input logic rn, input logic ew, input logic [3:0] aw,
                      input logic [KS2*DW-1:0] d, input logic er, input logic [7:0] ar);
    rst_n      = rn;
    ena_w      = ew;
    addr_write = aw;
    din        = d;
    ena_r      = er;
    addr_read  = ar;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] exp);
    n_cmp++;
    if (dout !== exp) begin
      n_fail++;
      $display("FAIL %s: dout=%h expected=%h", name, dout, exp);
    end
  endtask

  logic [KS2*DW-1:0] d0, d1, d_ones, d15, d_zero;

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    m_valid = 1'b0;
    m_dout  = 16'h0000;
    d0     = {16'h3c00,16'h4000,16'h0000,16'h3c00,16'h4000,16'h3c00,16'h4200,16'h4000,16'h3c00};
    d1     = {16'h0000,16'h4200,16'h0000,16'h3c00,16'h4000,16'h3c00,16'h4200,16'h4000,16'h3c00};
    d_ones = {KS2{16'h1111}};
    d15    = {16'hbeef,16'h0008,16'h0007,16'h0006,16'h0005,16'h0004,16'h0003,16'h0002,16'h0001};
    d_zero = {KS2*DW{1'b0}};
    rst_n = 1'b0; ena_w = 1'b0; addr_write = 4'd0; din = d_zero; ena_r = 1'b0; addr_read = 8'd0;

    step(1'b0, 1'b0, 4'd0, d_zero, 1'b1, 8'd2);   chk("reset_dout", 16'h0000);
    step(1'b1, 1'b1, 4'd0, d0,     1'b0, 8'd0);   chk("write_no_dout_change", 16'h0000);
    step(1'b1, 1'b1, 4'd1, d_ones, 1'b1, 8'd2);   chk("read_addr2", 16'h4200);
    step(1'b1, 1'b0, 4'd0, d_zero, 1'b1, 8'd7);   chk("read_addr7", 16'h4000);
    step(1'b1, 1'b1, 4'd1, d1,     1'b1, 8'd16);
`ifdef WEIGHT_RAM_WR_FWD_EN
    chk("same_cycle_fwd", 16'h4200);
`else
    chk("same_cycle_read_first", 16'h1111);
`endif
    step(1'b1, 1'b0, 4'd0, d_zero, 1'b1, 8'd3);   chk("read_addr3", 16'h3c00);
    step(1'b1, 1'b0, 4'd0, d_zero, 1'b1, 8'd16);  chk("read_addr16", 16'h4200);
    step(1'b1, 1'b0, 4'd0, d_zero, 1'b1, 8'd17);  chk("read_addr17", 16'h0000);
    step(1'b1, 1'b0, 4'd0, d_zero, 1'b1, 8'd16);  chk("read_addr16_again", 16'h4200);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'd0, d_zero, 1'b0, 8'd3); chk("hold_ena_r0", 16'h4200);
    end
    step(1'b1, 1'b0, 4'd0, d_zero, 1'b1, 8'd200); chk("oor_addr200", 16'h0000);
    step(1'b1, 1'b1, 4'd15, d15,   1'b0, 8'd0);   chk("hold_after_oor", 16'h0000);
    step(1'b1, 1'b0, 4'd0, d_zero, 1'b1, 8'd143); chk("read_last_word", 16'hbeef);
    step(1'b1, 1'b0, 4'd0, d_zero, 1'b1, 8'd144); chk("oor_addr144", 16'h0000);
    step(1'b1, 1'b0, 4'd0, d_zero, 1'b1, 8'd135); chk("read_slice15_e0", 16'h0001);
    step(1'b0, 1'b1, 4'd0, d_zero, 1'b1, 8'd16);  chk("reset_wins_read", 16'h0000);
    step(1'b1, 1'b0, 4'd0, d_zero, 1'b1, 8'd2);   chk("retained_addr2", 16'h4200);
    step(1'b1, 1'b0, 4'd0, d_zero, 1'b1, 8'd0);   chk("retained_addr0", 16'h3c00);
    // Sweep all words of slices 0 and 1 against the model.
    for (int a = 0; a < 18; a++) begin
      step(1'b1, 1'b0, 4'd0, d_zero, 1'b1, 8'(a));
    end
    step(1'b1, 1'b0, 4'd0, d_zero, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
